// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: synchronous FIFO with count, threshold flags and overflow/underflow pulses.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is registered read data.
module sync_fifo_flags #(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_WIDTH = 8,
  parameter int AF_LEVEL   = FIFO_DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  w_en,
  input  logic                  r_en,
  input  logic [FIFO_WIDTH-1:0] data_in,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CW-1:0]         count,
  output logic                  overflow,
  output logic                  underflow
);
  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [CW-1:0] wp, rp;
  logic wr_ok, rd_ok;
  assign full         = count == CW'(FIFO_DEPTH);
  assign empty        = count == '0;
  assign almost_full  = count >= CW'(AF_LEVEL);
  assign almost_empty = count <= CW'(AE_LEVEL);
  assign wr_ok = w_en & ~full & ~clr;
  assign rd_ok = r_en & ~empty & ~clr;
  // storage is deliberately left out of reset and flush
  always_ff @(posedge clk)
    if (wr_ok) mem[wp[AW-1:0]] <= data_in;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wp        <= clr ? '0 : wp + CW'(wr_ok);
      rp        <= clr ? '0 : rp + CW'(rd_ok);
      count     <= clr ? '0 : count + CW'(wr_ok) - CW'(rd_ok);
      overflow  <= w_en & full & ~clr;
      underflow <= r_en & empty & ~clr;
    end
  end
`ifdef FIFO_FWFT_EN
  always_comb data_out = empty ? '0 : mem[rp[AW-1:0]];
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_out <= '0;
    else if (clr) data_out <= '0;
    else if (rd_ok) data_out <= mem[rp[AW-1:0]];
  end
`endif
endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: directed self-checking bench for sync_fifo_flags (depth 4, registered read mode).
module tb_sync_fifo_flags;
  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0, w_en = 1'b0, r_en = 1'b0;
  logic [7:0] data_in = '0, data_out;
  logic full, empty, almost_full, almost_empty, overflow, underflow;
  logic [2:0] count;
  int total = 0, bad = 0;

  sync_fifo_flags #(.FIFO_DEPTH(4), .FIFO_WIDTH(8), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .w_en(w_en), .r_en(r_en), .data_in(data_in),
    .data_out(data_out), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    w_en = 1'b1; r_en = 1'b0; data_in = d;
    tick();
    w_en = 1'b0;
  endtask

  initial begin
    #3;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_af", almost_full, 0);
    chk("rst_count", count, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    @(negedge clk) rst_n = 1'b1;
    push(8'h11); chk("w1_count", count, 1); chk("w1_ae", almost_empty, 1); chk("w1_empty", empty, 0);
    push(8'h22); chk("w2_count", count, 2); chk("w2_ae", almost_empty, 0); chk("w2_af", almost_full, 0);
    push(8'h33); chk("w3_count", count, 3); chk("w3_af", almost_full, 1); chk("w3_full", full, 0);
    push(8'h44); chk("w4_count", count, 4); chk("w4_full", full, 1); chk("w4_ovf", overflow, 0);
    push(8'h55); chk("ovf_pulse", overflow, 1); chk("ovf_count", count, 4);
    tick(); chk("ovf_clear", overflow, 0);
    r_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rd_data", data_out, 8'h11 * (i + 1));
      chk("rd_count", count, 3 - i);
    end
    chk("rd_empty", empty, 1);
    tick(); chk("unf_pulse", underflow, 1); chk("unf_count", count, 0); chk("unf_dout", data_out, 8'h44);
    r_en = 1'b0;
    tick(); chk("unf_clear", underflow, 0);
    push(8'hA0); push(8'hA1);
    w_en = 1'b1; r_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data_in = 8'hA2 + 8'(i);
      tick();
      chk("wrap_count", count, 2);
      chk("wrap_data", data_out, 8'hA0 + 8'(i));
    end
    w_en = 1'b0; r_en = 1'b0;
    push(8'hAA); push(8'hAB); chk("refill_full", full, 1);
    w_en = 1'b1; r_en = 1'b1; data_in = 8'hCC;
    tick(); chk("fullrw_count", count, 3); chk("fullrw_ovf", overflow, 1); chk("fullrw_data", data_out, 8'hA8);
    r_en = 1'b0; clr = 1'b1; data_in = 8'hDD;
    tick(); chk("clr_count", count, 0); chk("clr_empty", empty, 1); chk("clr_dout", data_out, 0); chk("clr_ovf", overflow, 0);
    clr = 1'b0; w_en = 1'b0;
    push(8'h01); push(8'h02);
    r_en = 1'b1; tick(); r_en = 1'b0; chk("pre_rst_dout", data_out, 8'h01);
    w_en = 1'b1; data_in = 8'h03;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_count", count, 0); chk("arst_empty", empty, 1); chk("arst_dout", data_out, 0);
    #2 rst_n = 1'b1;
    data_in = 8'h77;
    tick(); w_en = 1'b0; chk("post_rst_count", count, 1);
    r_en = 1'b1; tick(); r_en = 1'b0;
    chk("post_rst_data", data_out, 8'h77); chk("post_rst_empty", empty, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
